// File: rtl/decrypt_round_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | decrypt_round_sequencer_if : block source/sink handshakes + round datapath  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface decrypt_round_sequencer_if #(
  parameter int RW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [127:0]   dp_state;
  logic [127:0]   dp_result;
  logic [1:0]     dp_mode;
  logic [RW-1:0]  key_idx;
  logic [RW-1:0]  round_num;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;
  logic           busy;

  // master: the sequencer; slave: block source, block sink and round datapath
  modport master (
    input  in_valid, in_data, dp_result, out_ready,
    output in_ready, dp_state, dp_mode, key_idx, round_num, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, dp_result, out_ready,
    input  in_ready, dp_state, dp_mode, key_idx, round_num, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/decrypt_round_sequencer.sv
// +----------------------------------------------------------------------------+
// | decrypt_round_sequencer : iterative AES-256 inverse-cipher round controller |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module decrypt_round_sequencer #(
  parameter int NUM_ROUNDS = 14,
  parameter int RW         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  decrypt_round_sequencer_if.master     bus
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_init  = 3'd1;
  localparam logic [2:0] c_st_round = 3'd2;
  localparam logic [2:0] c_st_final = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [1:0] c_mode_addkey = 2'd0;
  localparam logic [1:0] c_mode_round  = 2'd1;
  localparam logic [1:0] c_mode_final  = 2'd2;

  localparam logic [RW-1:0] c_one        = RW'(1);
  localparam logic [RW-1:0] c_last_round = RW'(NUM_ROUNDS - 1);
  localparam logic [RW-1:0] c_final_key  = RW'(NUM_ROUNDS);
  localparam logic [RW-1:0] c_rnum_base  = RW'(NUM_ROUNDS + 1);

  logic [2:0]    r_fsm;
  logic [2:0]    w_fsm_nxt;
  logic [127:0]  r_state;
  logic [127:0]  w_state_nxt;
  logic [RW-1:0] r_cnt;
  logic [RW-1:0] w_cnt_nxt;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_fsm)
      c_st_idle: begin
        if (bus.in_valid) begin
          w_state_nxt = bus.in_data;
          w_cnt_nxt   = c_one;
          w_fsm_nxt   = c_st_init;
        end
      end
      c_st_init: begin
        w_state_nxt = bus.dp_result;
        w_fsm_nxt   = c_st_round;
      end
      c_st_round: begin
        w_state_nxt = bus.dp_result;
        if (r_cnt < c_final_key) begin
          w_cnt_nxt = r_cnt + c_one;
        end
        // >= rather than == so a corrupted counter still terminates the block
        if (r_cnt >= c_last_round) begin
          w_fsm_nxt = c_st_final;
        end
      end
      c_st_final: begin
        w_state_nxt = bus.dp_result;
        w_fsm_nxt   = c_st_done;
      end
      c_st_done: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_state_nxt = bus.in_data;
            w_cnt_nxt   = c_one;
            w_fsm_nxt   = c_st_init;
          end else begin
            w_fsm_nxt = c_st_idle;
          end
        end
      end
      default: begin
        w_fsm_nxt   = c_st_idle;
        w_state_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm   <= c_st_idle;
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Datapath controls decode from registered state only; in_ready is the sole
  // output that looks at an input (out_ready, for back-to-back handoff in DONE).
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.dp_mode   = c_mode_addkey;
    bus.key_idx   = '0;
    bus.round_num = '0;
    case (r_fsm)
      c_st_idle: begin
        bus.in_ready = 1'b1;
      end
      c_st_init: begin
        bus.busy = 1'b1;
      end
      c_st_round: begin
        bus.busy      = 1'b1;
        bus.dp_mode   = c_mode_round;
        bus.key_idx   = r_cnt;
        bus.round_num = c_rnum_base - r_cnt;
      end
      c_st_final: begin
        bus.busy      = 1'b1;
        bus.dp_mode   = c_mode_final;
        bus.key_idx   = c_final_key;
        bus.round_num = c_one;
      end
      c_st_done: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign bus.dp_state = r_state;
  assign bus.out_data = r_state;

endmodule

`default_nettype wire

// File: tb/tb_decrypt_round_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_decrypt_round_sequencer : bench with an AES-256 round datapath and model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_decrypt_round_sequencer;

  localparam int NR  = 14;
  localparam int RW  = 4;
  localparam int LAT = NR + 1;

  typedef logic [14:0][127:0] ks_t;

  typedef struct packed {
    logic          iv;
    logic          ordy;
    logic [127:0]  din;
    logic [1:0]    mode;
    logic [RW-1:0] kidx;
    logic [RW-1:0] rnum;
    logic          bsy;
    logic          ov;
    logic          ir;
    logic          dchk;
    logic [127:0]  dexp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  ks_t  rks;

  decrypt_round_sequencer_if #(.RW(RW)) bus ();

  decrypt_round_sequencer #(.NUM_ROUNDS(NR), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- AES primitives (byte i of a block = bits 127-8i..120-8i)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, base);
      base = gm(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin
      m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
    end else begin
      m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(s[127-8*(4*c+j) -: 8], m[(j - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic ks_t keyexp(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    ks_t         ks;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Forward cipher: the bench's reference for what the sequencer must undo.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input ks_t ks);
    logic [127:0] s = pt ^ ks[0];
    for (int r = 1; r < NR; r++) s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ ks[r];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ ks[NR];
  endfunction

  // Key slot k holds encryption round key NR-k.
  function automatic logic [127:0] dp_fn(input logic [127:0] st, input logic [1:0] mode,
                                         input logic [RW-1:0] k, input ks_t ks);
    logic [127:0] rk;
    logic [127:0] t;
    if (int'(k) > NR) return '0;
    rk = ks[NR - int'(k)];
    t  = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk;
    case (mode)
      2'd0:    return st ^ rk;
      2'd1:    return mix_cols(t, 1'b1);
      2'd2:    return t;
      default: return '0;
    endcase
  endfunction

  assign bus.dp_result = dp_fn(bus.dp_state, bus.dp_mode, bus.key_idx, rks);

  // ---------------- checking helpers
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(bus.in_ready),  128'd1);
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_busy"},      128'(bus.busy),      128'd0);
    chk({tag, "_dp_mode"},   128'(bus.dp_mode),   128'd0);
    chk({tag, "_key_idx"},   128'(bus.key_idx),   128'd0);
    chk({tag, "_round_num"}, 128'(bus.round_num), 128'd0);
    chk({tag, "_out_data"},  bus.out_data,        128'd0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
  endtask

  // Call one cycle after a posedge with the DUT in IDLE; returns likewise.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int stall);
    int n;
    logic [127:0] held;
    bus.in_valid  = 1'b1;
    bus.in_data   = ct;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_accept_ready"}, 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    wait_valid(n);
    chk({tag, "_latency"}, 128'(n - 1), 128'(LAT));
    chk({tag, "_data"}, bus.out_data, pt);
    held = bus.out_data;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk({tag, "_stall_valid"}, 128'(bus.out_valid), 128'd1);
      chk({tag, "_stall_ready"}, 128'(bus.in_ready), 128'd0);
      chk({tag, "_stall_data"}, bus.out_data, held);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence
  initial begin
    logic [255:0] fips_key;
    logic [127:0] fips_ct, fips_pt, pt2, ct2;
    logic [127:0] pts [4];
    logic [127:0] cts [4];
    logic [127:0] exp_q [$];
    vec_t         tbl [27];
    int           n, sent, got, last;

    fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    fips_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
    fips_pt  = 128'h00112233445566778899aabbccddeeff;
    rks      = keyexp(fips_key);
    pt2      = {$urandom, $urandom, $urandom, $urandom};
    ct2      = encrypt(pt2, rks);

    // Row k (k=1..) is the k-th cycle after the accepting edge of row 0.
    tbl[0] = '{1'b1, 1'b0, fips_ct, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
    tbl[1] = '{1'b0, 1'b0, 128'd0,  2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 128'd0};
    for (int c = 1; c < NR; c++)
      tbl[c+1] = '{1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 2'd1,
                   RW'(c), RW'(NR + 1 - c), 1'b1, 1'b0, 1'b0, 1'b0, 128'd0};
    tbl[15] = '{1'b0, 1'b0, 128'd0, 2'd2, 4'd14, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 128'd0};
    for (int r = 16; r < 26; r++)
      tbl[r] = '{1'b1, 1'b0, ct2, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, fips_pt};
    tbl[26] = '{1'b1, 1'b1, ct2, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, fips_pt};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset held, then idle with nothing offered
    #2 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_in_ready",  128'(bus.in_ready),  128'd1);
      chk("idle_out_valid", 128'(bus.out_valid), 128'd0);
      chk("idle_busy",      128'(bus.busy),      128'd0);
    end
    @(posedge clk); #1;

    // FIPS-197 vector with per-cycle sequence trace and backpressure in DONE
    for (int r = 0; r < 27; r++) begin
      bus.in_valid  = tbl[r].iv;
      bus.out_ready = tbl[r].ordy;
      bus.in_data   = tbl[r].din;
      @(negedge clk);
      chk($sformatf("row%0d_dp_mode", r),   128'(bus.dp_mode),   128'(tbl[r].mode));
      chk($sformatf("row%0d_key_idx", r),   128'(bus.key_idx),   128'(tbl[r].kidx));
      chk($sformatf("row%0d_round_num", r), 128'(bus.round_num), 128'(tbl[r].rnum));
      chk($sformatf("row%0d_busy", r),      128'(bus.busy),      128'(tbl[r].bsy));
      chk($sformatf("row%0d_out_valid", r), 128'(bus.out_valid), 128'(tbl[r].ov));
      chk($sformatf("row%0d_in_ready", r),  128'(bus.in_ready),  128'(tbl[r].ir));
      if (tbl[r].dchk) chk($sformatf("row%0d_out_data", r), bus.out_data, tbl[r].dexp);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_valid(n);
    chk("handoff_latency", 128'(n - 1), 128'(LAT));
    chk("handoff_data", bus.out_data, pt2);
    @(posedge clk); #1;

    // Back-to-back: a new block is handed in during each DONE cycle
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = encrypt(pts[i], rks);
    end
    sent = 0; got = 0; last = -1;
    bus.in_valid  = 1'b1;
    bus.in_data   = cts[0];
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("b2b_unexpected_block", 128'd1, 128'd0);
        else chk($sformatf("b2b_data%0d", got), bus.out_data, exp_q.pop_front());
        // DONE cycle plus the accept-to-valid latency
        if (last >= 0) chk("b2b_spacing", 128'(cyc - last), 128'(LAT + 1));
        last = cyc;
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(pts[sent]);
        sent++;
      end
      @(posedge clk); #1;
      if (sent < 4) bus.in_data = cts[sent];
      else bus.in_valid = 1'b0;
    end
    chk("b2b_count", 128'(got), 128'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    // Randomized keys, blocks and sink stalls against the forward-cipher model
    for (int b = 0; b < 6; b++) begin
      logic [255:0] key;
      logic [127:0] pt;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      rks = keyexp(key);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_block($sformatf("rnd%0d", b), encrypt(pt, rks), pt, $urandom_range(0, 4));
    end

    // Reset in the middle of ROUND discards the block
    rks = keyexp(fips_key);
    bus.in_valid = 1'b1;
    bus.in_data  = fips_ct;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.busy && bus.key_idx == RW'(7)) && n < 40);
    chk("midrst_reach_cnt7", 128'(bus.key_idx), 128'd7);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("post_rst_busy",      128'(bus.busy),      128'd0);
      chk("post_rst_in_ready",  128'(bus.in_ready),  128'd1);
    end
    @(posedge clk); #1;
    run_block("after_rst", fips_ct, fips_pt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
